// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller beside the ID stage: load-use and branch-operand
// stalls, multi-cycle load stall, data-memory freeze, IF/ID flush, stall counter.
module hazard_stall_ctrl #(
  parameter int unsigned REG_W        = 5,
  parameter int unsigned INSTR_W      = 32,
  parameter int unsigned LOAD_LAT     = 1,
  parameter int unsigned BRANCH_IN_ID = 1,
  parameter int unsigned PERF_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ID_ExMemRead,
  input  logic               ID_ExRegWrite,
  input  logic [REG_W-1:0]   ID_Ex_Rt,
  input  logic [REG_W-1:0]   ID_Ex_Rd,
  input  logic               Ex_MemMemRead,
  input  logic [REG_W-1:0]   Ex_Mem_Rd,
  input  logic [INSTR_W-1:0] IF_ID_Instr,
  input  logic               branch_taken,
  input  logic               mem_wait,
  output logic               holdPC,
  output logic               holdIF_ID,
  output logic               ORgate_In,
  output logic               freeze_all,
  output logic               flush_IF_ID,
  output logic [PERF_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {IDLE, LSTALL, FREEZE} state_t;

  state_t            r_state;
  state_t            r_saved;
  logic [2:0]        r_cnt;
  logic [PERF_W-1:0] r_stall_cnt;

  logic [5:0]       w_opcode;
  logic [REG_W-1:0] w_rs;
  logic [REG_W-1:0] w_rt;
  logic             w_uses_rt;
  logic             w_is_branch;
  logic             w_load_use;
  logic             w_dep_a;
  logic             w_dep_b;
  logic             w_br_dep;
  state_t           w_cur;
  logic             w_unused_bits;

  assign w_opcode      = IF_ID_Instr[INSTR_W-1 -: 6];
  assign w_rs          = REG_W'(IF_ID_Instr[25:21]);
  assign w_rt          = REG_W'(IF_ID_Instr[20:16]);
  assign w_unused_bits = ^IF_ID_Instr[15:0];

  assign w_uses_rt   = (w_opcode == 6'h00) || (w_opcode == 6'h04) ||
                       (w_opcode == 6'h05) || (w_opcode == 6'h2B);
  assign w_is_branch = (w_opcode == 6'h04) || (w_opcode == 6'h05);

  assign w_load_use = ID_ExMemRead && (ID_Ex_Rt != '0) &&
                      ((ID_Ex_Rt == w_rs) || (w_uses_rt && (ID_Ex_Rt == w_rt)));
  assign w_dep_a    = ID_ExRegWrite && (ID_Ex_Rd != '0) &&
                      ((ID_Ex_Rd == w_rs) || (ID_Ex_Rd == w_rt));
  assign w_dep_b    = Ex_MemMemRead && (Ex_Mem_Rd != '0) &&
                      ((Ex_Mem_Rd == w_rs) || (Ex_Mem_Rd == w_rt));
  assign w_br_dep   = (BRANCH_IN_ID != 0) && w_is_branch && (w_dep_a || w_dep_b);

  // While frozen the saved state is the one that governs behaviour once mem_wait drops
  assign w_cur = (r_state == FREEZE) ? r_saved : r_state;

  always_comb begin
    holdPC      = 1'b0;
    holdIF_ID   = 1'b0;
    ORgate_In   = 1'b0;
    freeze_all  = 1'b0;
    flush_IF_ID = 1'b0;
    if (!rst_n) begin
      holdPC = 1'b0;
    end else if (mem_wait) begin
      freeze_all = 1'b1;
      holdPC     = 1'b1;
      holdIF_ID  = 1'b1;
    end else if (w_cur == LSTALL || w_load_use || w_br_dep) begin
      holdPC    = 1'b1;
      holdIF_ID = 1'b1;
      ORgate_In = 1'b1;
    end else if (branch_taken) begin
      flush_IF_ID = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_saved     <= IDLE;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (holdPC && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;

      if (mem_wait) begin
        if (r_state != FREEZE)
          r_saved <= r_state;
        r_state <= FREEZE;
      end else begin
        case (w_cur)
          LSTALL: begin
            r_cnt   <= r_cnt - 3'd1;
            r_state <= (r_cnt == 3'd1) ? IDLE : LSTALL;
          end
          default: begin
            if (w_load_use && (LOAD_LAT > 1)) begin
              r_state <= LSTALL;
              r_cnt   <= 3'(LOAD_LAT - 1);
            end else begin
              r_state <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a LOAD_LAT=1 branch-mode instance and a
// LOAD_LAT=3, branch-check-off, 4-bit-counter instance driven by shared inputs.
module tb_hazard_stall_ctrl;

  localparam logic [31:0] ADD_T1_T0_T2 = {6'h00, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] ADD_T1_0_T2  = {6'h00, 5'd0, 5'd10, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] LW_T0_T3     = {6'h23, 5'd11, 5'd8, 16'h0000};
  localparam logic [31:0] SW_T0_T3     = {6'h2B, 5'd11, 5'd8, 16'h0000};
  localparam logic [31:0] BEQ_T0_T1    = {6'h04, 5'd8, 5'd9, 16'h0004};
  localparam logic [31:0] BEQ_0_T1     = {6'h04, 5'd0, 5'd9, 16'h0004};

  logic        clk;
  logic        rst_n;
  logic        ID_ExMemRead;
  logic        ID_ExRegWrite;
  logic [4:0]  ID_Ex_Rt;
  logic [4:0]  ID_Ex_Rd;
  logic        Ex_MemMemRead;
  logic [4:0]  Ex_Mem_Rd;
  logic [31:0] IF_ID_Instr;
  logic        branch_taken;
  logic        mem_wait;

  logic        a_holdPC, a_holdIF_ID, a_ORgate_In, a_freeze_all, a_flush_IF_ID;
  logic [15:0] a_stall_cycles;
  logic        b_holdPC, b_holdIF_ID, b_ORgate_In, b_freeze_all, b_flush_IF_ID;
  logic [3:0]  b_stall_cycles;

  logic [4:0] w1;
  logic [4:0] w3;
  assign w1 = {a_holdPC, a_holdIF_ID, a_ORgate_In, a_freeze_all, a_flush_IF_ID};
  assign w3 = {b_holdPC, b_holdIF_ID, b_ORgate_In, b_freeze_all, b_flush_IF_ID};

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  hazard_stall_ctrl #(.REG_W(5), .INSTR_W(32), .LOAD_LAT(1), .BRANCH_IN_ID(1), .PERF_W(16)) d1 (
    .clk(clk), .rst_n(rst_n), .ID_ExMemRead(ID_ExMemRead), .ID_ExRegWrite(ID_ExRegWrite),
    .ID_Ex_Rt(ID_Ex_Rt), .ID_Ex_Rd(ID_Ex_Rd), .Ex_MemMemRead(Ex_MemMemRead), .Ex_Mem_Rd(Ex_Mem_Rd),
    .IF_ID_Instr(IF_ID_Instr), .branch_taken(branch_taken), .mem_wait(mem_wait),
    .holdPC(a_holdPC), .holdIF_ID(a_holdIF_ID), .ORgate_In(a_ORgate_In),
    .freeze_all(a_freeze_all), .flush_IF_ID(a_flush_IF_ID), .stall_cycles(a_stall_cycles)
  );

  hazard_stall_ctrl #(.REG_W(5), .INSTR_W(32), .LOAD_LAT(3), .BRANCH_IN_ID(0), .PERF_W(4)) d3 (
    .clk(clk), .rst_n(rst_n), .ID_ExMemRead(ID_ExMemRead), .ID_ExRegWrite(ID_ExRegWrite),
    .ID_Ex_Rt(ID_Ex_Rt), .ID_Ex_Rd(ID_Ex_Rd), .Ex_MemMemRead(Ex_MemMemRead), .Ex_Mem_Rd(Ex_Mem_Rd),
    .IF_ID_Instr(IF_ID_Instr), .branch_taken(branch_taken), .mem_wait(mem_wait),
    .holdPC(b_holdPC), .holdIF_ID(b_holdIF_ID), .ORgate_In(b_ORgate_In),
    .freeze_all(b_freeze_all), .flush_IF_ID(b_flush_IF_ID), .stall_cycles(b_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ID_ExMemRead  = 1'b0;
    ID_ExRegWrite = 1'b0;
    ID_Ex_Rt      = 5'd0;
    ID_Ex_Rd      = 5'd0;
    Ex_MemMemRead = 1'b0;
    Ex_Mem_Rd     = 5'd0;
    IF_ID_Instr   = 32'h0000_0000;
    branch_taken  = 1'b0;
    mem_wait      = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic load_hazard;
    ID_ExMemRead = 1'b1;
    ID_Ex_Rt     = 5'd8;
    IF_ID_Instr  = ADD_T1_T0_T2;
  endtask

  // Outputs are packed as {holdPC, holdIF_ID, ORgate_In, freeze_all, flush_IF_ID}
  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    load_hazard();
    branch_taken = 1'b1;
    #1;
    n_checks++; if (w1 !== 5'b00000) begin n_errors++; $display("FAIL rst_forced_a ctl=%b exp=%b", w1, 5'b00000); end
    n_checks++; if (w3 !== 5'b00000) begin n_errors++; $display("FAIL rst_forced_b ctl=%b exp=%b", w3, 5'b00000); end
    cyc();
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    n_checks++; if (w1 !== 5'b00000) begin n_errors++; $display("FAIL rst_idle_a ctl=%b exp=%b", w1, 5'b00000); end
    n_checks++; if (a_stall_cycles !== 16'd0) begin n_errors++; $display("FAIL rst_cnt_a got=%0d exp=0", a_stall_cycles); end
    n_checks++; if (b_stall_cycles !== 4'd0) begin n_errors++; $display("FAIL rst_cnt_b got=%0d exp=0", b_stall_cycles); end
    cyc();
  endtask

  task automatic test_load_use;
    do_reset();
    load_hazard();
    @(negedge clk);
    n_checks++; if (w1 !== 5'b11100) begin n_errors++; $display("FAIL lu_c0_a ctl=%b exp=%b", w1, 5'b11100); end
    n_checks++; if (w3 !== 5'b11100) begin n_errors++; $display("FAIL lu_c0_b ctl=%b exp=%b", w3, 5'b11100); end
    cyc();
    ID_ExMemRead = 1'b0;
    @(negedge clk);
    n_checks++; if (w1 !== 5'b00000) begin n_errors++; $display("FAIL lu_c1_a ctl=%b exp=%b", w1, 5'b00000); end
    n_checks++; if (w3 !== 5'b11100) begin n_errors++; $display("FAIL lu_c1_b ctl=%b exp=%b", w3, 5'b11100); end
    n_checks++; if (a_stall_cycles !== 16'd1) begin n_errors++; $display("FAIL lu_cnt_a got=%0d exp=1", a_stall_cycles); end
    cyc();
    @(negedge clk);
    n_checks++; if (w3 !== 5'b11100) begin n_errors++; $display("FAIL lu_c2_b ctl=%b exp=%b", w3, 5'b11100); end
    cyc();
    @(negedge clk);
    n_checks++; if (w3 !== 5'b00000) begin n_errors++; $display("FAIL lu_c3_b ctl=%b exp=%b", w3, 5'b00000); end
    n_checks++; if (b_stall_cycles !== 4'd3) begin n_errors++; $display("FAIL lu_cnt_b got=%0d exp=3", b_stall_cycles); end
    n_checks++; if (a_stall_cycles !== 16'd1) begin n_errors++; $display("FAIL lu_cnt_a_end got=%0d exp=1", a_stall_cycles); end
    cyc();
  endtask

  task automatic test_no_hazard;
    do_reset();
    ID_ExMemRead = 1'b1;
    ID_Ex_Rt     = 5'd0;
    IF_ID_Instr  = ADD_T1_0_T2;
    @(negedge clk);
    n_checks++; if (w1 !== 5'b00000) begin n_errors++; $display("FAIL r0_rs_a ctl=%b exp=%b", w1, 5'b00000); end
    n_checks++; if (w3 !== 5'b00000) begin n_errors++; $display("FAIL r0_rs_b ctl=%b exp=%b", w3, 5'b00000); end
    cyc();
    ID_Ex_Rt = 5'd8;
    IF_ID_Instr = LW_T0_T3;
    @(negedge clk);
    n_checks++; if (w1 !== 5'b00000) begin n_errors++; $display("FAIL lw_rt_a ctl=%b exp=%b", w1, 5'b00000); end
    n_checks++; if (w3 !== 5'b00000) begin n_errors++; $display("FAIL lw_rt_b ctl=%b exp=%b", w3, 5'b00000); end
    cyc();
    IF_ID_Instr = SW_T0_T3;
    @(negedge clk);
    n_checks++; if (w1 !== 5'b11100) begin n_errors++; $display("FAIL sw_rt_a ctl=%b exp=%b", w1, 5'b11100); end
    cyc();
  endtask

  task automatic test_branch;
    do_reset();
    ID_ExRegWrite = 1'b1;
    ID_Ex_Rd      = 5'd9;
    IF_ID_Instr   = BEQ_T0_T1;
    branch_taken  = 1'b1;
    @(negedge clk);
    n_checks++; if (w1 !== 5'b11100) begin n_errors++; $display("FAIL br_exdep_a ctl=%b exp=%b", w1, 5'b11100); end
    n_checks++; if (w3 !== 5'b00001) begin n_errors++; $display("FAIL br_off_b ctl=%b exp=%b", w3, 5'b00001); end
    cyc();
    ID_ExRegWrite = 1'b0;
    Ex_MemMemRead = 1'b1;
    Ex_Mem_Rd     = 5'd8;
    @(negedge clk);
    n_checks++; if (w1 !== 5'b11100) begin n_errors++; $display("FAIL br_memdep_a ctl=%b exp=%b", w1, 5'b11100); end
    cyc();
    Ex_MemMemRead = 1'b0;
    @(negedge clk);
    n_checks++; if (w1 !== 5'b00001) begin n_errors++; $display("FAIL br_flush_a ctl=%b exp=%b", w1, 5'b00001); end
    cyc();
    branch_taken  = 1'b0;
    ID_ExRegWrite = 1'b1;
    ID_Ex_Rd      = 5'd0;
    IF_ID_Instr   = BEQ_0_T1;
    @(negedge clk);
    n_checks++; if (w1 !== 5'b00000) begin n_errors++; $display("FAIL br_r0_a ctl=%b exp=%b", w1, 5'b00000); end
    cyc();
    ID_Ex_Rd    = 5'd9;
    IF_ID_Instr = ADD_T1_T0_T2;
    @(negedge clk);
    n_checks++; if (w1 !== 5'b00000) begin n_errors++; $display("FAIL br_notbr_a ctl=%b exp=%b", w1, 5'b00000); end
    cyc();
  endtask

  task automatic test_mem_wait;
    do_reset();
    load_hazard();
    @(negedge clk);
    n_checks++; if (w3 !== 5'b11100) begin n_errors++; $display("FAIL mw_c0_b ctl=%b exp=%b", w3, 5'b11100); end
    cyc();
    ID_ExMemRead = 1'b0;
    mem_wait     = 1'b1;
    branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (w3 !== 5'b11010) begin n_errors++; $display("FAIL mw_frz%0d_b ctl=%b exp=%b", i, w3, 5'b11010); end
      n_checks++; if (w1 !== 5'b11010) begin n_errors++; $display("FAIL mw_frz%0d_a ctl=%b exp=%b", i, w1, 5'b11010); end
      cyc();
    end
    mem_wait     = 1'b0;
    branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (w3 !== 5'b11100) begin n_errors++; $display("FAIL mw_res%0d_b ctl=%b exp=%b", i, w3, 5'b11100); end
      n_checks++; if (w1 !== 5'b00000) begin n_errors++; $display("FAIL mw_res%0d_a ctl=%b exp=%b", i, w1, 5'b00000); end
      cyc();
    end
    @(negedge clk);
    n_checks++; if (w3 !== 5'b00000) begin n_errors++; $display("FAIL mw_end_b ctl=%b exp=%b", w3, 5'b00000); end
    n_checks++; if (b_stall_cycles !== 4'd5) begin n_errors++; $display("FAIL mw_cnt_b got=%0d exp=5", b_stall_cycles); end
    n_checks++; if (a_stall_cycles !== 16'd3) begin n_errors++; $display("FAIL mw_cnt_a got=%0d exp=3", a_stall_cycles); end
    cyc();
  endtask

  task automatic test_reset_mid_stall;
    do_reset();
    load_hazard();
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (w3 !== 5'b00000) begin n_errors++; $display("FAIL rm_forced_b ctl=%b exp=%b", w3, 5'b00000); end
    cyc();
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    n_checks++; if (w3 !== 5'b00000) begin n_errors++; $display("FAIL rm_idle_b ctl=%b exp=%b", w3, 5'b00000); end
    n_checks++; if (b_stall_cycles !== 4'd0) begin n_errors++; $display("FAIL rm_cnt_b got=%0d exp=0", b_stall_cycles); end
    cyc();
    @(negedge clk);
    n_checks++; if (w3 !== 5'b00000) begin n_errors++; $display("FAIL rm_after_b ctl=%b exp=%b", w3, 5'b00000); end
    cyc();
  endtask

  task automatic test_saturation;
    do_reset();
    mem_wait = 1'b1;
    repeat (20) cyc();
    mem_wait = 1'b0;
    @(negedge clk);
    n_checks++; if (b_stall_cycles !== 4'd15) begin n_errors++; $display("FAIL sat_cnt_b got=%0d exp=15", b_stall_cycles); end
    n_checks++; if (a_stall_cycles !== 16'd20) begin n_errors++; $display("FAIL sat_cnt_a got=%0d exp=20", a_stall_cycles); end
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_mem_wait();
    test_reset_mid_stall();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
